// File: rtl/mem_pkg.sv
// Shared types for the MEM pipeline stage: control bundle, FSM states and
// error-flag bit positions.
package mem_pkg;

    typedef struct packed {
        logic branch;
        logic memread;
        logic memwrite;
        logic regwrite;
        logic memtoreg;
    } ctrl_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_TIMEOUT  = 1;

endpackage

// File: rtl/flopenr.sv
// Enable-gated register with asynchronous active-high clear; used for the
// EX/MEM and MEM/WB pipeline registers.
module flopenr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/memory_access.sv
// LEGv8 MEM stage: EX/MEM register, variable-latency data memory handshake
// with timeout, CBZ resolution and the MEM/WB register.
module memory_access
    import mem_pkg::*;
#(
    parameter int N       = 64,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_E,
    input  logic         flush_E,
    input  logic [N-1:0] aluResult_E,
    input  logic [N-1:0] writeData_E,
    input  logic [N-1:0] PCBranch_E,
    input  logic         zero_E,
    input  logic [4:0]   ctrl_E,
    input  logic [4:0]   rd_E,
    output logic         dm_req,
    output logic         dm_we,
    output logic [N-1:0] dm_addr,
    output logic [N-1:0] dm_wdata,
    input  logic         dm_ack,
    input  logic [N-1:0] dm_rdata,
    output logic         stall_M,
    output logic         PCSrc_M,
    output logic [N-1:0] PCBranch_M,
    output logic         valid_W,
    output logic [N-1:0] readData_W,
    output logic [N-1:0] aluResult_W,
    output logic [4:0]   rd_W,
    output logic         RegWrite_W,
    output logic         MemtoReg_W,
    output logic [1:0]   err_M
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int MW = 1 + 5 + 5 + 1 + 3 * N;
    localparam int WW = 1 + 1 + 5 + 2 * N;

    ctrl_t        ctrl_in;
    logic         in_mem_op;
    logic         load_m;

    logic [MW-1:0] m_d, m_q;
    logic          m_valid;
    ctrl_t         m_ctrl;
    logic [4:0]    m_rd;
    logic          m_zero;
    logic [N-1:0]  m_addr, m_wdata, m_pcbranch;

    logic          mem_op, misaligned, kill;

    mem_state_t    state, state_n;
    logic [CW-1:0] wait_cnt, cnt_n;
    logic [N-1:0]  mem_data, data_n;
    logic          timed_out, to_n;
    logic [1:0]    err, err_n;

    logic [WW-1:0] w_d, w_q;
    logic          w_regwrite, w_memtoreg;

    assign ctrl_in   = ctrl_E;
    assign in_mem_op = valid_E & ~flush_E & (ctrl_in.memread | ctrl_in.memwrite);
    assign load_m    = ~stall_M;

    // EX/MEM register; a flush only matters on the cycle the bundle is captured.
    assign m_d = {valid_E & ~flush_E, ctrl_E, rd_E, zero_E, aluResult_E, writeData_E, PCBranch_E};

    flopenr #(.W(MW)) u_m_reg (
        .clk   (clk),
        .reset (reset),
        .en    (load_m),
        .d     (m_d),
        .q     (m_q)
    );

    assign {m_valid, m_ctrl, m_rd, m_zero, m_addr, m_wdata, m_pcbranch} = m_q;

    assign mem_op     = m_valid & (m_ctrl.memread | m_ctrl.memwrite);
    assign misaligned = mem_op & (m_addr[2:0] != 3'b000);
    assign kill       = misaligned | timed_out;

    // Stall is a function of registered state only, so dm_ack never reaches it.
    assign stall_M = mem_op & (state != DONE) & ~misaligned;

    assign dm_req   = (state == BUSY);
    assign dm_we    = dm_req & m_ctrl.memwrite;
    assign dm_addr  = m_addr;
    assign dm_wdata = m_wdata;

    assign PCSrc_M    = m_valid & m_ctrl.branch & m_zero;
    assign PCBranch_M = m_pcbranch;
    assign err_M      = err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            mem_data  <= '0;
            timed_out <= 1'b0;
            err       <= 2'b00;
        end else begin
            state     <= state_n;
            wait_cnt  <= cnt_n;
            mem_data  <= data_n;
            timed_out <= to_n;
            err       <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = wait_cnt;
        data_n  = mem_data;
        to_n    = timed_out;
        err_n   = err;

        case (state)
            IDLE: begin
                if (mem_op & ~misaligned) begin
                    state_n = BUSY;
                    cnt_n   = '0;
                end
            end
            BUSY: begin
                if (dm_ack) begin
                    state_n = DONE;
                    data_n  = dm_rdata;
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    state_n             = DONE;
                    data_n              = '0;
                    to_n                = 1'b1;
                    err_n[ERR_TIMEOUT]  = 1'b1;
                end else begin
                    cnt_n = wait_cnt + CW'(1);
                end
            end
            DONE: begin
                state_n = DONE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (misaligned) begin
            err_n[ERR_MISALIGN] = 1'b1;
        end

        // A new instruction entering M goes straight to BUSY when it needs the
        // memory, so a zero-wait access costs exactly one stall cycle.
        if (load_m) begin
            state_n = (in_mem_op & (aluResult_E[2:0] == 3'b000)) ? BUSY : IDLE;
            cnt_n   = '0;
            data_n  = '0;
            to_n    = 1'b0;
        end
    end

    assign w_d = {m_ctrl.regwrite & ~kill, m_ctrl.memtoreg, m_rd, mem_data, m_addr};

    flopenr #(.W(WW)) u_w_reg (
        .clk   (clk),
        .reset (reset),
        .en    (load_m),
        .d     (w_d),
        .q     (w_q)
    );

    // A stalled M stage hands a bubble to writeback every cycle.
    flopenr #(.W(1)) u_w_valid (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .d     (m_valid & load_m),
        .q     (valid_W)
    );

    assign {w_regwrite, w_memtoreg, rd_W, readData_W, aluResult_W} = w_q;
    assign RegWrite_W = valid_W & w_regwrite;
    assign MemtoReg_W = valid_W & w_memtoreg;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: a latency-programmable memory
// responder and a scoreboard of expected writeback results.
module tb_memory_access;

    localparam int N       = 64;
    localparam int TIMEOUT = 16;

    localparam logic [4:0] C_LOAD  = 5'b01011;
    localparam logic [4:0] C_STORE = 5'b00100;
    localparam logic [4:0] C_ALU   = 5'b00010;
    localparam logic [4:0] C_CBZ   = 5'b10000;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         valid_E = 1'b0;
    logic         flush_E = 1'b0;
    logic [N-1:0] aluResult_E = '0;
    logic [N-1:0] writeData_E = '0;
    logic [N-1:0] PCBranch_E = '0;
    logic         zero_E = 1'b0;
    logic [4:0]   ctrl_E = '0;
    logic [4:0]   rd_E = '0;
    logic         dm_req, dm_we;
    logic [N-1:0] dm_addr, dm_wdata;
    logic         dm_ack = 1'b0;
    logic [N-1:0] dm_rdata = '0;
    logic         stall_M, PCSrc_M;
    logic [N-1:0] PCBranch_M;
    logic         valid_W;
    logic [N-1:0] readData_W, aluResult_W;
    logic [4:0]   rd_W;
    logic         RegWrite_W, MemtoReg_W;
    logic [1:0]   err_M;

    memory_access #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_E     (valid_E),
        .flush_E     (flush_E),
        .aluResult_E (aluResult_E),
        .writeData_E (writeData_E),
        .PCBranch_E  (PCBranch_E),
        .zero_E      (zero_E),
        .ctrl_E      (ctrl_E),
        .rd_E        (rd_E),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_ack      (dm_ack),
        .dm_rdata    (dm_rdata),
        .stall_M     (stall_M),
        .PCSrc_M     (PCSrc_M),
        .PCBranch_M  (PCBranch_M),
        .valid_W     (valid_W),
        .readData_W  (readData_W),
        .aluResult_W (aluResult_W),
        .rd_W        (rd_W),
        .RegWrite_W  (RegWrite_W),
        .MemtoReg_W  (MemtoReg_W),
        .err_M       (err_M)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [134:0] got, input logic [134:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory responder: ack arrives in the ack_after-th request cycle (0 = never).
    int          ack_after = 1;
    logic [N-1:0] rdata_cfg = '0;
    int          busy_cnt = 0;
    int          req_cycles = 0;
    int          stall_cycles = 0;
    logic [N-1:0] exp_addr = '0;
    logic [N-1:0] exp_wdata = '0;
    logic        exp_we = 1'b0;

    always @(negedge clk) begin
        if (stall_M) stall_cycles++;
        if (dm_req) begin
            req_cycles++;
            busy_cnt++;
            check("dm_addr", dm_addr, exp_addr);
            check("dm_we", dm_we, exp_we);
            if (exp_we) check("dm_wdata", dm_wdata, exp_wdata);
            dm_ack   = (busy_cnt == ack_after);
            dm_rdata = dm_ack ? (dm_we ? '0 : rdata_cfg) : 64'hA5A5_A5A5_A5A5_A5A5;
        end else begin
            busy_cnt = 0;
            dm_ack   = 1'b0;
            dm_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
        end
    end

    // Scoreboard of {rd, RegWrite, MemtoReg, aluResult, readData}.
    logic [134:0] exp_q[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (valid_W) begin
                if (exp_q.size() == 0) check("w_unexpected", valid_W, 1'b0);
                else check("w_result", {rd_W, RegWrite_W, MemtoReg_W, aluResult_W, readData_W},
                           exp_q.pop_front());
            end else begin
                check("w_bubble_ctrl", {RegWrite_W, MemtoReg_W}, 2'b00);
            end
        end
    end

    task automatic wait_stall();
        int n = 0;
        while (stall_M && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (stall_M) check("stall_bound", stall_M, 1'b0);
    endtask

    task automatic send(input logic v, input logic fl, input logic [4:0] c,
                        input logic [N-1:0] alu, input logic [N-1:0] wd,
                        input logic [N-1:0] pcb, input logic z, input logic [4:0] rd);
        logic mop, mis, to, rw;
        logic [N-1:0] rdx;
        mop = c[3] | c[2];
        mis = mop && (alu[2:0] != 3'b000);
        to  = mop && !mis && (ack_after == 0);
        rdx = (c[3] && !mis && !to) ? rdata_cfg : '0;
        rw  = c[1] & ~mis & ~to;
        exp_addr  = alu;
        exp_we    = c[2];
        exp_wdata = wd;
        valid_E = v; flush_E = fl; ctrl_E = c; aluResult_E = alu;
        writeData_E = wd; PCBranch_E = pcb; zero_E = z; rd_E = rd;
        if (v && !fl) exp_q.push_back({rd, rw, c[0], alu, rdx});
        wait_stall();
        @(negedge clk);
        valid_E = 1'b0;
        flush_E = 1'b0;
        wait_stall();
    endtask

    task automatic clear_counts();
        req_cycles   = 0;
        stall_cycles = 0;
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] a;
        int kind;

        repeat (2) @(negedge clk);
        check("rst_dm_req", dm_req, 1'b0);
        check("rst_stall", stall_M, 1'b0);
        check("rst_valid_w", valid_W, 1'b0);
        check("rst_err", err_M, 2'b00);
        check("rst_pcsrc", PCSrc_M, 1'b0);
        check("rst_pcbranch", PCBranch_M, 64'd0);
        check("rst_readdata", readData_W, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Store, zero-wait memory.
        ack_after = 1; clear_counts();
        send(1, 0, C_STORE, 64'h40, 64'hDEAD_BEEF, 64'd0, 0, 5'd0);
        drain();
        check("st_req_cycles", req_cycles, 1);
        check("st_stall_cycles", stall_cycles, 1);

        // Load acked in the third request cycle.
        ack_after = 3; rdata_cfg = 64'h1234; clear_counts();
        send(1, 0, C_LOAD, 64'h80, 64'd0, 64'd0, 0, 5'd9);
        drain();
        check("ld_req_cycles", req_cycles, 3);
        check("ld_stall_cycles", stall_cycles, 3);

        // Load that never completes.
        ack_after = 0; clear_counts();
        send(1, 0, C_LOAD, 64'h100, 64'd0, 64'd0, 0, 5'd10);
        check("to_err", err_M, 2'b10);
        check("to_stall_cycles", stall_cycles, TIMEOUT);
        check("to_req_cycles", req_cycles, TIMEOUT);
        drain();
        check("to_err_sticky", err_M, 2'b10);

        // Misaligned load.
        ack_after = 1; clear_counts();
        send(1, 0, C_LOAD, 64'h43, 64'd0, 64'd0, 0, 5'd11);
        drain();
        check("mis_req_cycles", req_cycles, 0);
        check("mis_stall_cycles", stall_cycles, 0);
        check("mis_err", err_M, 2'b11);

        // CBZ taken, followed by a flushed instruction.
        clear_counts();
        send(1, 0, C_CBZ, 64'd0, 64'd0, 64'h1000, 1, 5'd0);
        check("cbz_pcsrc", PCSrc_M, 1'b1);
        check("cbz_pcbranch", PCBranch_M, 64'h1000);
        send(1, 1, C_LOAD | C_CBZ, 64'h88, 64'd0, 64'h2000, 1, 5'd12);
        check("flush_pcsrc", PCSrc_M, 1'b0);
        check("flush_req_cycles", req_cycles, 0);
        send(1, 0, C_CBZ, 64'd0, 64'd0, 64'h3000, 0, 5'd0);
        check("cbz_nt_pcsrc", PCSrc_M, 1'b0);
        check("cbz_nt_pcbranch", PCBranch_M, 64'h3000);
        drain();

        // Random mix of ALU ops, loads and stores with short latencies.
        for (int i = 0; i < 12; i++) begin
            kind      = $urandom_range(0, 2);
            ack_after = $urandom_range(1, 4);
            rdata_cfg = {$urandom, $urandom};
            a         = {$urandom, $urandom};
            a[2:0]    = 3'b000;
            clear_counts();
            case (kind)
                0: send(1, 0, C_ALU, a, 64'd0, 64'd0, 0, 5'($urandom_range(1, 31)));
                1: send(1, 0, C_LOAD, a, 64'd0, 64'd0, 0, 5'($urandom_range(1, 31)));
                default: send(1, 0, C_STORE, a, {$urandom, $urandom}, 64'd0, 0, 5'd0);
            endcase
            check("rnd_stall_cycles", stall_cycles, (kind == 0) ? 0 : ack_after);
        end
        drain();

        // Reset in the middle of an outstanding access.
        ack_after = 0;
        exp_addr = 64'h200; exp_we = 1'b0;
        valid_E = 1; flush_E = 0; ctrl_E = C_LOAD; aluResult_E = 64'h200; rd_E = 5'd14;
        @(negedge clk);
        check("mid_req", dm_req, 1'b1);
        check("mid_stall", stall_M, 1'b1);
        valid_E = 0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_busy_req", dm_req, 1'b0);
        check("rst_busy_stall", stall_M, 1'b0);
        check("rst_busy_valid_w", valid_W, 1'b0);
        check("rst_busy_err", err_M, 2'b00);
        check("rst_busy_addr", dm_addr, 64'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        ack_after = 2; rdata_cfg = 64'h5555; clear_counts();
        send(1, 0, C_LOAD, 64'h208, 64'd0, 64'd0, 0, 5'd13);
        drain();
        check("post_rst_req_cycles", req_cycles, 2);
        check("post_rst_err", err_M, 2'b00);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
